// File: rtl/jctr_sequencer_if.sv
// Command/status bundle between the run controller and its host.
// The master issues commands and watches status; the slave is the sequencer.
interface jctr_sequencer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) ();
    logic             start;
    logic             mode;
    logic             dir;
    logic             cont;
    logic [CNT_W-1:0] steps;
    logic             hold;
    logic             abort;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             step;
    logic             done;

    modport master (
        output start, mode, dir, cont, steps, hold, abort,
        input  out, busy, step, done
    );

    modport slave (
        input  start, mode, dir, cont, steps, hold, abort,
        output out, busy, step, done
    );
endinterface

// File: rtl/jctr_sequencer.sv
// Run controller for a ring/Johnson shift counter: latches a command, then
// performs exactly the requested number of shifts with pause and abort.
module jctr_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic            clk,
    input logic            rstn,
    jctr_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = out_q;
        unique case ({mode_q, dir_q})
            2'b00:   shifted = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            2'b01:   shifted = {out_q[0], out_q[WIDTH-1:1]};
            2'b10:   shifted = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
            default: shifted = {~out_q[0], out_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.steps != '0) begin
                        state_d     = StRun;
                        mode_d      = bus.mode;
                        dir_d       = bus.dir;
                        remaining_d = bus.steps;
                        if (!bus.cont) begin
                            out_d = bus.mode ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        // Zero-length run completes without touching the counter.
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (bus.hold) begin
                    state_d = StPause;
                end else begin
                    out_d       = shifted;
                    step_d      = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = StDone;
                    end
                end
            end
            StPause: begin
                if (bus.abort) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (!bus.hold) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            out_q       <= '0;
            remaining_q <= '0;
            mode_q      <= 1'b0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = (state_q == StRun) || (state_q == StPause);
    assign bus.step = step_q;
    assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_jctr_sequencer.sv
// Scoreboard bench for jctr_sequencer: expected counter values are queued per
// command and checked against every step pulse.
module tb_jctr_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    jctr_sequencer_if #(.WIDTH(W), .CNT_W(CW)) ifc ();

    jctr_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc)
    );

    int total    = 0;
    int bad      = 0;
    int step_cnt = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] model_shift(input logic m, input logic d,
                                                 input logic [W-1:0] v);
        logic [W-1:0] r;
        if (!m && !d)     r = {v[W-2:0], v[W-1]};
        else if (!m && d) r = {v[0], v[W-1:1]};
        else if (m && !d) r = {v[W-2:0], ~v[W-1]};
        else              r = {~v[0], v[W-1:1]};
        return r;
    endfunction

    task automatic push_model(input logic m, input logic d, input logic [W-1:0] seed,
                              input int n);
        logic [W-1:0] v;
        v = seed;
        for (int i = 0; i < n; i++) begin
            v = model_shift(m, d, v);
            exp_q.push_back(v);
        end
    endtask

    // Advance to the next falling edge and score any step pulse seen there.
    task automatic tick();
        logic [W-1:0] e;
        @(negedge clk);
        if (ifc.step === 1'b1) begin
            total++;
            step_cnt++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL step_unexpected out=%b queue empty", ifc.out);
            end else begin
                e = exp_q.pop_front();
                if (ifc.out !== e) begin
                    bad++;
                    $display("FAIL step_out got=%b exp=%b", ifc.out, e);
                end
            end
        end
        if (ifc.done === 1'b1) done_cnt++;
    endtask

    task automatic issue(input logic m, input logic d, input logic c, input int n);
        ifc.mode  = m;
        ifc.dir   = d;
        ifc.cont  = c;
        ifc.steps = n[CW-1:0];
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output int cyc);
        cyc = 1;
        while (ifc.done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        total++;
        if (ifc.done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout got=%0d cycles exp<%0d", cyc, budget);
        end
        tick();
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [W:0] got, input logic [W:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        check_vec("reset_out", {1'b0, ifc.out}, '0);
        check_vec("reset_flags", {2'b0, ifc.busy, ifc.step, ifc.done}, '0);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_johnson_left();
        int cyc;
        logic [W-1:0] tbl [8];
        tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        step_cnt = 0;
        done_cnt = 0;
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        issue(1'b1, 1'b0, 1'b0, 8);
        check_vec("t1_busy", {4'b0, ifc.busy}, 5'b00001);
        run_until_done(20, cyc);
        check_int("t1_latency", cyc, 9);
        check_int("t1_steps", step_cnt, 8);
        check_int("t1_done", done_cnt, 1);
        check_int("t1_queue", exp_q.size(), 0);
    endtask

    task automatic test_ring_dir_cont();
        int cyc;
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [3];
        ta = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        tb = '{4'b0001, 4'b1000, 4'b0100};
        step_cnt = 0;
        done_cnt = 0;
        foreach (ta[i]) exp_q.push_back(ta[i]);
        issue(1'b0, 1'b0, 1'b0, 5);
        run_until_done(20, cyc);
        check_int("t2a_steps", step_cnt, 5);
        foreach (tb[i]) exp_q.push_back(tb[i]);
        issue(1'b0, 1'b1, 1'b1, 3);
        run_until_done(20, cyc);
        check_int("t2b_steps", step_cnt, 8);
        check_int("t2_done", done_cnt, 2);
        check_vec("t2_final", {1'b0, ifc.out}, 5'b00100);
    endtask

    task automatic test_hold();
        int cyc;
        step_cnt = 0;
        done_cnt = 0;
        push_model(1'b1, 1'b0, 4'b0000, 8);
        issue(1'b1, 1'b0, 1'b0, 8);
        cyc = 1;
        while (ifc.done !== 1'b1 && cyc < 40) begin
            if (cyc == 4) ifc.hold = 1'b1;
            if (cyc == 6) ifc.hold = 1'b0;
            if (cyc >= 5 && cyc <= 7) begin
                check_vec("t3_frozen", {ifc.busy, ifc.out}, 5'b10111);
            end
            tick();
            cyc++;
        end
        check_int("t3_latency", cyc, 12);
        tick();
        check_int("t3_steps", step_cnt, 8);
        check_int("t3_done", done_cnt, 1);
    endtask

    task automatic test_abort();
        step_cnt = 0;
        done_cnt = 0;
        push_model(1'b1, 1'b0, 4'b0000, 3);
        issue(1'b1, 1'b0, 1'b0, 8);
        for (int c = 1; c < 4; c++) begin
            if (c == 2) begin
                ifc.mode  = 1'b0;
                ifc.cont  = 1'b0;
                ifc.steps = 8'd1;
                ifc.start = 1'b1;
            end
            if (c == 3) ifc.start = 1'b0;
            tick();
        end
        ifc.abort = 1'b1;
        tick();
        check_vec("t4_after_abort", {ifc.busy, ifc.out}, 5'b00111);
        repeat (3) tick();
        ifc.abort = 1'b0;
        repeat (5) tick();
        check_vec("t4_held", {ifc.busy, ifc.out}, 5'b00111);
        check_int("t4_steps", step_cnt, 3);
        check_int("t4_no_done", done_cnt, 0);
        check_int("t4_queue", exp_q.size(), 0);
    endtask

    task automatic test_boundary();
        int cyc;
        step_cnt = 0;
        done_cnt = 0;
        issue(1'b0, 1'b0, 1'b0, 0);
        check_vec("t5_zero_done", {4'b0, ifc.done}, 5'b00001);
        run_until_done(5, cyc);
        check_int("t5_zero_latency", cyc, 1);
        check_int("t5_zero_steps", step_cnt, 0);
        check_vec("t5_zero_out", {1'b0, ifc.out}, 5'b00111);
        push_model(1'b0, 1'b0, 4'b0001, 255);
        issue(1'b0, 1'b0, 1'b0, 255);
        run_until_done(300, cyc);
        check_int("t5_max_latency", cyc, 256);
        check_int("t5_max_steps", step_cnt, 255);
        check_int("t5_done", done_cnt, 2);
        check_vec("t5_max_out", {1'b0, ifc.out}, 5'b01000);
    endtask

    task automatic test_reset_midrun();
        int cyc;
        step_cnt = 0;
        done_cnt = 0;
        push_model(1'b1, 1'b0, 4'b0000, 8);
        issue(1'b1, 1'b0, 1'b0, 8);
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check_vec("t6_async_out", {1'b0, ifc.out}, '0);
        check_vec("t6_async_flags", {2'b0, ifc.busy, ifc.step, ifc.done}, '0);
        exp_q.delete();
        tick();
        rstn = 1'b1;
        tick();
        step_cnt = 0;
        done_cnt = 0;
        push_model(1'b1, 1'b0, 4'b0000, 3);
        issue(1'b1, 1'b0, 1'b0, 3);
        run_until_done(20, cyc);
        check_int("t6_rerun_latency", cyc, 4);
        check_int("t6_rerun_steps", step_cnt, 3);
        check_vec("t6_rerun_out", {1'b0, ifc.out}, 5'b00111);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.mode  = 1'b0;
        ifc.dir   = 1'b0;
        ifc.cont  = 1'b0;
        ifc.steps = '0;
        ifc.hold  = 1'b0;
        ifc.abort = 1'b0;
        test_reset();
        test_johnson_left();
        test_ring_dir_cont();
        test_hold();
        test_abort();
        test_boundary();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
